// File: rtl/posit_field_decoder.sv
// Two-stage posit unpacker: stage 1 takes the sign and magnitude, stage 2 decodes
// regime, exponent and fraction. A single advance enable stalls both stages together.
module posit_field_decoder #(
  parameter int unsigned N      = 16,
  parameter int unsigned ES     = 1,
  parameter int unsigned K_BITS = $clog2(N) + 1,
  parameter int unsigned F_BITS = N - 3 - ES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N-1:0]      posit_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              sign_o,
  output logic [K_BITS-1:0] k_o,
  output logic [ES-1:0]     exp_o,
  output logic [F_BITS-1:0] frac_o,
  output logic              is_zero_o,
  output logic              is_nar_o
);

  localparam int unsigned M_BITS = $clog2(N) + 1;
  localparam int unsigned T_BITS = N - 3;

  logic adv;

  logic         s1_valid;
  logic         s1_sign;
  logic [N-2:0] s1_r;
  logic         s1_zero;
  logic         s1_nar;

  logic [N-2:0]        r_in_c;
  logic                zero_in_c;
  logic                nar_in_c;
  logic                r0_c;
  logic                stop_c;
  logic [M_BITS-1:0]   m_c;
  logic [T_BITS-1:0]   tail_c;
  logic [K_BITS-1:0]   k_c;
  logic [ES-1:0]       exp_c;
  logic [F_BITS-1:0]   frac_c;
  logic                special_c;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;

  // Only the low N-1 bits of the magnitude matter: the top bit is 0 for every
  // non-NaR posit, and NaR is flagged separately.
  always_comb begin
    r_in_c    = posit_i[N-1] ? ((N-1)'(~posit_i[N-2:0]) + (N-1)'(1)) : posit_i[N-2:0];
    zero_in_c = (posit_i == '0);
    nar_in_c  = (posit_i == {1'b1, {(N-1){1'b0}}});
  end

  // Regime run length, then left-align the bits that follow the terminator.
  always_comb begin
    r0_c   = s1_r[N-2];
    m_c    = M_BITS'(1);
    stop_c = 1'b0;
    for (int i = int'(N) - 3; i >= 0; i--) begin
      if (!stop_c && (s1_r[i] == r0_c)) begin
        m_c = m_c + M_BITS'(1);
      end else begin
        stop_c = 1'b1;
      end
    end
    tail_c    = s1_r[N-4:0] << (m_c - M_BITS'(1));
    k_c       = r0_c ? (K_BITS'(m_c) - K_BITS'(1)) : (K_BITS'(0) - K_BITS'(m_c));
    exp_c     = tail_c[T_BITS-1 -: ES];
    frac_c    = tail_c[F_BITS-1:0];
    special_c = s1_zero || s1_nar;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_r        <= '0;
      s1_zero     <= 1'b0;
      s1_nar      <= 1'b0;
      out_valid_o <= 1'b0;
      sign_o      <= 1'b0;
      k_o         <= '0;
      exp_o       <= '0;
      frac_o      <= '0;
      is_zero_o   <= 1'b0;
      is_nar_o    <= 1'b0;
    end else if (adv) begin
      s1_valid    <= in_valid_i;
      s1_sign     <= posit_i[N-1];
      s1_r        <= r_in_c;
      s1_zero     <= zero_in_c;
      s1_nar      <= nar_in_c;
      out_valid_o <= s1_valid;
      sign_o      <= s1_sign;
      k_o         <= special_c ? '0 : k_c;
      exp_o       <= special_c ? '0 : exp_c;
      frac_o      <= special_c ? '0 : frac_c;
      is_zero_o   <= s1_zero;
      is_nar_o    <= s1_nar;
    end
  end

endmodule

// File: doc/posit_field_decoder.md
Name: posit_field_decoder

Overview:
- Two-stage pipelined posit unpacker. Splits an N-bit posit into sign, signed regime value k, exponent field and left-aligned fraction, and flags zero/NaR.
- Sits directly upstream of the total-exponent stage: its k_o and exp_o feed that stage's k and exponent inputs unchanged.
- valid/ready handshake on both sides, with a global stall so the pipeline never drops or duplicates a beat.

Parameters:
- N, 16, posit width in bits; N >= ES+4.
- ES, 1, exponent field width; ES >= 1.
- K_BITS, $clog2(N)+1, width of signed regime value k_o.
- F_BITS, N-3-ES, width of fraction output.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  decoder can accept a beat this cycle.
- posit_i  in  N  raw posit bits.
- out_valid_o  out  1  decoded beat valid.
- out_ready_i  in  1  consumer accepts the beat.
- sign_o  out  1  posit sign bit.
- k_o  out  K_BITS  signed regime value.
- exp_o  out  ES  exponent field, zero-padded if truncated.
- frac_o  out  F_BITS  fraction bits, MSB-aligned, zero-padded; hidden bit not included.
- is_zero_o  out  1  posit == 0.
- is_nar_o  out  1  posit == 1 followed by N-1 zeros (NaR).

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - Clears both stage valid bits and every output register: out_valid_o, sign_o, k_o, exp_o, frac_o, is_zero_o, is_nar_o all 0.
  - Reset has priority over any transfer that cycle.
  - A beat in flight when reset is asserted is discarded.
- Stall rule:
  - adv = !out_valid_o || out_ready_i.
  - in_ready_o = adv (combinational).
  - When adv = 0, both stages hold all registers.
  - When adv = 1, stage 2 loads from stage 1 and stage 1 loads from the input.
  - Stage 1 valid <= in_valid_i. Stage 2 valid (out_valid_o) <= stage 1 valid.
  - The output does not change while out_valid_o=1 and out_ready_i=0.
- Latency: 2 cycles from an accepted input to out_valid_o. Throughput is 1 beat/cycle when out_ready_i is held high.
- Stage 1 registers:
  - sign = posit_i[N-1].
  - abs = sign ? two's complement of posit_i : posit_i (N bits).
  - is_zero = (posit_i == 0).
  - is_nar = (posit_i == {1'b1, (N-1)'b0}).
- Stage 2 computes from the registered value r = abs[N-2:0]:
  - r0 = r[N-2].
  - m = run length of bits equal to r0 starting at bit N-2; 1 <= m <= N-1.
  - k = r0 ? m-1 : -m, sign-extended to K_BITS.
  - Discard m regime bits plus 1 terminator bit. When m = N-1 there is no terminator and no remaining bits.
  - The next ES bits form exp_o; missing bits are 0.
  - The following F_BITS bits form frac_o, MSB-aligned; missing bits are 0.
- Specials: if is_zero or is_nar, then k_o, exp_o and frac_o are 0, sign_o is the raw bit, and the matching flag is 1. Exactly one flag can be high at a time.
- Width rule: for N=16 the range of k is -15..+14 and fits in K_BITS = 5 signed bits. No saturation is needed for any legal N.
- Simultaneous in_valid_i and a stall: the input is not accepted (in_ready_o=0). The upstream must hold posit_i and in_valid_i until in_ready_o=1.

Test Plan (N=16, ES=1):
1. Basic decodes:
   - 0x4000 -> sign 0, k 0, exp 0, frac 0x000, 2 cycles after acceptance.
   - 0x5A00 -> k 0, exp 1, frac 0xA00.
   - 0x2000 -> k -1, exp 0, frac 0.
2. Extremes and negatives:
   - 0x7FFF -> k 14, exp 0, frac 0.
   - 0x0001 -> k -14, exp 0, frac 0.
   - 0xC000 -> sign 1, k 0, exp 0, frac 0.
3. Specials:
   - 0x0000 -> is_zero_o=1, is_nar_o=0, k/exp/frac 0.
   - 0x8000 -> is_nar_o=1, is_zero_o=0, sign_o=1, k/exp/frac 0.
4. Backpressure:
   - Stream 0x4000, 0x5A00, 0x2000 back-to-back; drop out_ready_i for 3 cycles after the first output appears.
   - Required: first output held stable, in_ready_o=0 during the stall, all three beats delivered in order with no duplicates.
5. Reset mid-flight:
   - Accept two beats, assert rst_i for 1 cycle.
   - Required: next cycle out_valid_o=0 and all outputs 0; no stale beat emerges afterwards.
6. Random stream:
   - 1000 random posits with random out_ready_i.
   - Required: every field matches a reference decoder model, in order, with zero loss.
